dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
//
// PURPOSE
// - Shares one single-port synchronous data memory between two requesters:
//   the instruction-fetch port (IF, read-only) and the lsu port (read/write).
// - The lsu port carries byte-lane write masks and word-aligned write data.
// - Sits between core fetch/lsu and the on-chip SRAM macro.
// - Arbitrates every cycle, launches at most one access per cycle, and routes
//   each read response back to the requester that issued it.
//
// PARAMETERS
// - ADDR_W    32  address width, both ports and memory
// - DATA_W    32  data width; mask width equals DATA_W (bit-granular enables)
// - MAX_WAIT  4   consecutive denied IF cycles before IF is forced to win; >=1
//
// PORTS
// - clk          in   1       clock, rising edge
// - rst_n        in   1       reset, asynchronous, active-low
// - if_req       in   1       IF read request; held with if_addr until if_gnt
// - if_addr      in   ADDR_W  IF read address
// - if_gnt       out  1       IF access launched this cycle
// - if_rvalid    out  1       IF read data valid (one cycle after if_gnt)
// - if_rdata     out  DATA_W  IF read data
// - lsu_req      in   1       lsu request; fields below held until lsu_gnt
// - lsu_we       in   1       1 = write, 0 = read
// - lsu_addr     in   ADDR_W  lsu address
// - lsu_bwe      in   DATA_W  lsu bit write enables (ignored on reads)
// - lsu_wdata    in   DATA_W  lsu write data, already lane-aligned
// - lsu_gnt      out  1       lsu access launched this cycle
// - lsu_rvalid   out  1       lsu read data valid (one cycle after read gnt)
// - lsu_rdata    out  DATA_W  lsu read data
// - mem_cs       out  1       memory chip select
// - mem_we       out  1       memory write enable
// - mem_addr     out  ADDR_W  memory address
// - mem_bwe      out  DATA_W  memory bit write enables
// - mem_wdata    out  DATA_W  memory write data
// - mem_rdata    in   DATA_W  memory read data, valid one cycle after cs & !we
//
// BEHAVIOUR
// - Grant is combinational, same cycle as request:
//   - mem_cs = if_gnt | lsu_gnt
//   - if_gnt and lsu_gnt are never both 1
//   - while rst_n = 0, if_gnt, lsu_gnt and mem_cs are forced to 0
// - Memory outputs:
//   - mem_* fields come from the granted requester
//   - idle: mem_addr, mem_wdata, mem_bwe and mem_we are all 0
//   - IF grant and lsu read: mem_bwe = 0, mem_we = 0
// - Priority (default): lsu wins a collision, unless starve_cnt == MAX_WAIT,
//   then IF wins.
// - starve_cnt, width $clog2(MAX_WAIT+1), reset 0:
//   - +1 on each cycle with if_req & !if_gnt, saturating at MAX_WAIT
//   - cleared on if_gnt or when if_req = 0
// - Read return:
//   - registered rd_owner {NONE, IF, LSU}, reset NONE
//   - loaded every cycle from this cycle's read grant (write or no grant -> NONE)
//   - if_rvalid = (rd_owner == IF); lsu_rvalid = (rd_owner == LSU); both reset 0
//   - if_rdata = lsu_rdata = mem_rdata (unqualified; use rvalid)
// - Writes:
//   - complete on lsu_gnt; no rvalid is produced
//   - a read to the same address on the next cycle returns the new data
// - Back-to-back grants are allowed every cycle. A response and a new grant
//   can occur in the same cycle.
// - Reset mid-operation: rd_owner clears asynchronously. An in-flight read
//   response is dropped and is never reissued.
// - No FIFO; a requester must not drop its request before gnt.
//
// CONFIGURATION
// - DMEM_ARB_RR_EN defined:
//   - round-robin on collision; registered last_winner, reset = IF, so the lsu
//     wins the first collision after reset
//   - winner = the port other than last_winner; last_winner updates on every grant
//   - starve_cnt logic is not built and MAX_WAIT is unused
// - DMEM_ARB_RR_EN undefined: fixed lsu priority with the starvation override
//   above.
//
// TESTING
// - rst_n=0, if_req=lsu_req=1 -> if_gnt=lsu_gnt=mem_cs=0; no rvalid for 2 cycles
//   after release until a grant.
// - lsu read only, addr 0x100 -> lsu_gnt=1, mem_addr=0x100, mem_we=0, mem_bwe=0;
//   next cycle lsu_rvalid=1, lsu_rdata=mem_rdata.
// - both req, lsu SB addr 0x203, bwe 0xFF000000, wdata 0xAB000000 ->
//   - lsu_gnt=1, if_gnt=0, mem_we=1, mem_bwe=0xFF000000
//   - no lsu_rvalid; IF granted next cycle once lsu_req drops
// - MAX_WAIT=4, both req held -> lsu granted cycles 0-3, IF granted cycle 4
//   (starve_cnt=4 -> 0), lsu cycle 5.
// - IF read cycle n, lsu read cycle n+1 -> if_rvalid at n+1 only, lsu_rvalid at
//   n+2 only, no overlap.
// - lsu read granted, rst_n low next cycle -> lsu_rvalid stays 0.
// - DMEM_ARB_RR_EN, both req held 4 cycles -> grants LSU, IF, LSU, IF.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// IF port is read-only; the lsu port reads and writes with bit write enables.
// Default build: fixed lsu priority with an IF starvation override after MAX_WAIT
// denied cycles. Define DMEM_ARB_RR_EN for round-robin on collisions instead.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_bwe_i,
   input  logic [DATA_W-1:0] lsu_wdata_i,
   output logic              lsu_gnt_o,
   output logic              lsu_rvalid_o,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic              mem_cs_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_bwe_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [1:0] OwnNone = 2'd0;
   localparam logic [1:0] OwnIf   = 2'd1;
   localparam logic [1:0] OwnLsu  = 2'd2;

   logic       if_win;
   logic       if_gnt;
   logic       lsu_gnt;
   logic [1:0] rd_owner_q, rd_owner_d;

`ifdef DMEM_ARB_RR_EN
   // last_lsu_q = 1 when the lsu took the most recent grant; reset favours the lsu.
   logic last_lsu_q, last_lsu_d;

   // IF wins alone, or on a collision when the lsu won last time.
   always_comb begin
      if_win = if_req_i & (~lsu_req_i | last_lsu_q);
   end

   // Track the most recent winner on every grant.
   always_comb begin
      last_lsu_d = last_lsu_q;
      if (lsu_gnt) begin
         last_lsu_d = 1'b1;
      end else if (if_gnt) begin
         last_lsu_d = 1'b0;
      end
   end

   // Last-winner register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_lsu_q <= 1'b0;
      end else begin
         last_lsu_q <= last_lsu_d;
      end
   end
`else
   localparam int unsigned       CntW     = $clog2(MAX_WAIT + 1);
   localparam logic [CntW-1:0]   MaxWaitC = CntW'(MAX_WAIT);

   logic [CntW-1:0] starve_q, starve_d;

   // lsu has priority unless IF has been denied MAX_WAIT cycles in a row.
   always_comb begin
      if_win = if_req_i & (~lsu_req_i | (starve_q == MaxWaitC));
   end

   // Count consecutive denied IF cycles, saturating; clear on grant or idle.
   always_comb begin
      starve_d = '0;
      if (if_req_i && !if_gnt) begin
         starve_d = (starve_q == MaxWaitC) ? starve_q : starve_q + CntW'(1);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   // Same-cycle grants, suppressed while reset is asserted.
   always_comb begin
      if_gnt  = rst_ni & if_win;
      lsu_gnt = rst_ni & lsu_req_i & ~if_win;
   end

   // Drive the memory from the granted port; all-zero fields when idle.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_bwe_o   = '0;
      mem_wdata_o = '0;
      if (if_gnt) begin
         mem_addr_o = if_addr_i;
      end else if (lsu_gnt) begin
         mem_addr_o = lsu_addr_i;
         if (lsu_we_i) begin
            mem_we_o    = 1'b1;
            mem_bwe_o   = lsu_bwe_i;
            mem_wdata_o = lsu_wdata_i;
         end
      end
   end

   // Remember who owns next cycle's read data; writes produce no response.
   always_comb begin
      rd_owner_d = OwnNone;
      if (if_gnt) begin
         rd_owner_d = OwnIf;
      end else if (lsu_gnt && !lsu_we_i) begin
         rd_owner_d = OwnLsu;
      end
   end

   // Read-owner register; async clear drops any in-flight response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_owner_q <= OwnNone;
      end else begin
         rd_owner_q <= rd_owner_d;
      end
   end

   assign if_gnt_o     = if_gnt;
   assign lsu_gnt_o    = lsu_gnt;
   assign mem_cs_o     = if_gnt | lsu_gnt;
   assign if_rvalid_o  = (rd_owner_q == OwnIf);
   assign lsu_rvalid_o = (rd_owner_q == OwnLsu);
   assign if_rdata_o   = mem_rdata_i;
   assign lsu_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural SRAM plus a reference memory image;
// read responses are checked against a scoreboard queue by a monitor process.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        lsu_req;
   logic        lsu_we;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_bwe;
   logic [31:0] lsu_wdata;
   logic        lsu_gnt;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        mem_cs;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_bwe;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   typedef struct packed {
      logic        is_if;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] sram    [256];
   logic [31:0] ref_mem [256];
   int          errors = 0;
   int          checks = 0;
   logic        mon_en = 1'b0;

   dmem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MAX_WAIT(4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_gnt_o    (if_gnt),
      .if_rvalid_o (if_rvalid),
      .if_rdata_o  (if_rdata),
      .lsu_req_i   (lsu_req),
      .lsu_we_i    (lsu_we),
      .lsu_addr_i  (lsu_addr),
      .lsu_bwe_i   (lsu_bwe),
      .lsu_wdata_i (lsu_wdata),
      .lsu_gnt_o   (lsu_gnt),
      .lsu_rvalid_o(lsu_rvalid),
      .lsu_rdata_o (lsu_rdata),
      .mem_cs_o    (mem_cs),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_bwe_o   (mem_bwe),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port SRAM with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we) begin
            sram[mem_addr[9:2]] <= (sram[mem_addr[9:2]] & ~mem_bwe) | (mem_wdata & mem_bwe);
         end else begin
            mem_rdata <= sram[mem_addr[9:2]];
         end
      end
   end

   // Response monitor: each cycle pops the read expected from the previous cycle.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (if_rvalid !== e.is_if || lsu_rvalid !== !e.is_if) begin
               errors++;
               $display("FAIL rvalid_owner: if_rvalid=%b lsu_rvalid=%b, required %b/%b",
                        if_rvalid, lsu_rvalid, e.is_if, !e.is_if);
            end
            checks++;
            if ((e.is_if ? if_rdata : lsu_rdata) !== e.data) begin
               errors++;
               $display("FAIL rdata: got %h, required %h", e.is_if ? if_rdata : lsu_rdata,
                        e.data);
            end
         end else begin
            checks++;
            if (if_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
               errors++;
               $display("FAIL spurious_rvalid: if_rvalid=%b lsu_rvalid=%b, required 0/0",
                        if_rvalid, lsu_rvalid);
            end
         end
      end
   end

   task automatic push_read(input logic is_if, input logic [31:0] addr);
      exp_t e;
      e.is_if = is_if;
      e.data  = ref_mem[addr[9:2]];
      exp_q.push_back(e);
   endtask

   task automatic drive_idle();
      if_req    = 1'b0;
      lsu_req   = 1'b0;
      lsu_we    = 1'b0;
      lsu_bwe   = '0;
      lsu_wdata = '0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      if_req   = 1'b1;
      lsu_req  = 1'b1;
      if_addr  = 32'h0000_0200;
      lsu_addr = 32'h0000_0100;
      lsu_we   = 1'b0;
      lsu_bwe  = '0;
      lsu_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b0 || lsu_gnt !== 1'b0 || mem_cs !== 1'b0) begin
         errors++;
         $display("FAIL reset_gnt: if_gnt=%b lsu_gnt=%b mem_cs=%b, required 0/0/0",
                  if_gnt, lsu_gnt, mem_cs);
      end
      checks++;
      if (if_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rvalid: %b/%b, required 0/0", if_rvalid, lsu_rvalid);
      end
      @(posedge clk); #1;
      drive_idle();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (mem_cs !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0 ||
             mem_bwe !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL idle_mem: cs=%b addr=%h we=%b bwe=%h wdata=%h, required all 0",
                     mem_cs, mem_addr, mem_we, mem_bwe, mem_wdata);
         end
      end
   endtask

   task automatic test_lsu_write();
      logic [31:0] idx;
      @(posedge clk); #1;
      if_req    = 1'b1;
      if_addr   = 32'h0000_0200;
      lsu_req   = 1'b1;
      lsu_we    = 1'b1;
      lsu_addr  = 32'h0000_0203;
      lsu_bwe   = 32'hFF00_0000;
      lsu_wdata = 32'hAB00_0000;
      @(negedge clk);
      checks++;
      if (lsu_gnt !== 1'b1 || if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL wr_gnt: lsu_gnt=%b if_gnt=%b, required 1/0", lsu_gnt, if_gnt);
      end
      checks++;
      if (mem_we !== 1'b1 || mem_bwe !== 32'hFF00_0000 || mem_wdata !== 32'hAB00_0000 ||
          mem_addr !== 32'h0000_0203) begin
         errors++;
         $display("FAIL wr_fields: we=%b bwe=%h wdata=%h addr=%h, required 1/ff000000/ab000000/203",
                  mem_we, mem_bwe, mem_wdata, mem_addr);
      end
      idx = 32'h0000_0203 >> 2;
      ref_mem[idx[7:0]] = (ref_mem[idx[7:0]] & 32'h00FF_FFFF) | 32'hAB00_0000;
      @(posedge clk); #1;
      lsu_req = 1'b0;
      lsu_we  = 1'b0;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || lsu_gnt !== 1'b0 || mem_addr !== 32'h0000_0200 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL if_after_wr: if_gnt=%b lsu_gnt=%b addr=%h we=%b, required 1/0/200/0",
                  if_gnt, lsu_gnt, mem_addr, mem_we);
      end
      push_read(1'b1, 32'h0000_0200);
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_lsu_read();
      @(posedge clk); #1;
      lsu_req   = 1'b1;
      lsu_we    = 1'b0;
      lsu_addr  = 32'h0000_0100;
      lsu_bwe   = 32'hFFFF_FFFF;
      lsu_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (lsu_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_cs !== 1'b1) begin
         errors++;
         $display("FAIL rd_gnt: lsu_gnt=%b if_gnt=%b cs=%b, required 1/0/1", lsu_gnt, if_gnt, mem_cs);
      end
      checks++;
      if (mem_addr !== 32'h0000_0100 || mem_we !== 1'b0 || mem_bwe !== 32'h0 ||
          mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL rd_fields: addr=%h we=%b bwe=%h wdata=%h, required 100/0/0/0",
                  mem_addr, mem_we, mem_bwe, mem_wdata);
      end
      push_read(1'b0, 32'h0000_0100);
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      if_req  = 1'b1;
      if_addr = 32'h0000_0208;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || lsu_gnt !== 1'b0) begin
         errors++;
         $display("FAIL b2b_if_gnt: if_gnt=%b lsu_gnt=%b, required 1/0", if_gnt, lsu_gnt);
      end
      push_read(1'b1, 32'h0000_0208);
      @(posedge clk); #1;
      if_req   = 1'b0;
      lsu_req  = 1'b1;
      lsu_we   = 1'b0;
      lsu_addr = 32'h0000_0108;
      @(negedge clk);
      checks++;
      if (lsu_gnt !== 1'b1 || if_gnt !== 1'b0 || if_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_lsu_gnt: lsu_gnt=%b if_gnt=%b if_rvalid=%b, required 1/0/1",
                  lsu_gnt, if_gnt, if_rvalid);
      end
      push_read(1'b0, 32'h0000_0108);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++;
      if (lsu_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_lsu_rvalid: lsu_rvalid=%b if_rvalid=%b, required 1/0",
                  lsu_rvalid, if_rvalid);
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      lsu_req  = 1'b1;
      lsu_we   = 1'b0;
      lsu_addr = 32'h0000_0100;
      @(negedge clk);
      checks++;
      if (lsu_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_gnt: lsu_gnt=%b, required 1", lsu_gnt);
      end
      @(posedge clk); #1;
      rst_n   = 1'b0;
      lsu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (lsu_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mid_drop: lsu_rvalid=%b if_rvalid=%b, required 0/0", lsu_rvalid, if_rvalid);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_starvation();
      logic exp_if;
      @(posedge clk); #1;
      if_req   = 1'b1;
      if_addr  = 32'h0000_0204;
      lsu_req  = 1'b1;
      lsu_we   = 1'b0;
      lsu_addr = 32'h0000_0104;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
`ifdef DMEM_ARB_RR_EN
         exp_if = (c % 2) == 1;
`else
         exp_if = (c == 4);
`endif
         checks++;
         if (if_gnt !== exp_if || lsu_gnt !== !exp_if) begin
            errors++;
            $display("FAIL collide_c%0d: if_gnt=%b lsu_gnt=%b, required %b/%b",
                     c, if_gnt, lsu_gnt, exp_if, !exp_if);
         end
         push_read(exp_if, exp_if ? 32'h0000_0204 : 32'h0000_0104);
         @(posedge clk); #1;
      end
      drive_idle();
   endtask

   task automatic test_write_read();
      logic [31:0] idx;
      @(posedge clk); #1;
      lsu_req   = 1'b1;
      lsu_we    = 1'b1;
      lsu_addr  = 32'h0000_010C;
      lsu_bwe   = 32'h0000_FFFF;
      lsu_wdata = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if (lsu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_bwe !== 32'h0000_FFFF) begin
         errors++;
         $display("FAIL wr2_gnt: lsu_gnt=%b we=%b bwe=%h, required 1/1/0000ffff",
                  lsu_gnt, mem_we, mem_bwe);
      end
      idx = 32'h0000_010C >> 2;
      ref_mem[idx[7:0]] = (ref_mem[idx[7:0]] & 32'hFFFF_0000) | 32'h0000_5678;
      @(posedge clk); #1;
      lsu_we = 1'b0;
      @(negedge clk);
      checks++;
      if (lsu_gnt !== 1'b1 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL rd2_gnt: lsu_gnt=%b we=%b, required 1/0", lsu_gnt, mem_we);
      end
      push_read(1'b0, 32'h0000_010C);
      @(posedge clk); #1;
      drive_idle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i]    = 32'hC0DE_0000 | (i * 32'h0001_0101);
         ref_mem[i] = 32'hC0DE_0000 | (i * 32'h0001_0101);
      end
      mem_rdata = '0;
      test_reset();
      test_lsu_write();
      test_lsu_read();
      test_back_to_back();
      test_reset_mid();
      test_starvation();
      test_write_read();
      repeat (3) @(posedge clk);
      #3;
      mon_en = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
